// File: rtl/frame_buffer_arbiter.sv
// Frame buffer arbiter: shares one single-port pixel RAM between a display
// read port (always wins) and a buffered edge-result write port. After reset
// the whole RAM is cleared to zero before normal arbitration starts.
//
// Handshakes:
//   write side - a write transfers on a rising edge where wrReq=1 and wrReady=1;
//                wrReady never depends on wrReq or on a same-cycle pop, and a
//                wrReq seen while wrReady=0 is dropped and flagged in overflow.
//   read side  - rdReq has no back-pressure; every rdReq is answered exactly one
//                cycle later by rdValid=1 with rdData, otherwise rdValid=0.
`timescale 1ns/1ps
module frame_buffer_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          mainClk,
    input  logic                          nreset,
    input  logic                          rdReq,
    input  logic [ADDR_W-1:0]             rdAddr,
    output logic [DATA_W-1:0]             rdData,
    output logic                          rdValid,
    input  logic                          wrReq,
    input  logic [ADDR_W-1:0]             wrAddr,
    input  logic [DATA_W-1:0]             wrData,
    output logic                          wrReady,
    output logic                          ramEn,
    output logic                          ramWe,
    output logic [ADDR_W-1:0]             ramAddr,
    output logic [DATA_W-1:0]             ramWrData,
    input  logic [DATA_W-1:0]             ramRdData,
    output logic                          clearing,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] CLR_LAST = '1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic {CLEAR, RUN} stateT;

    stateT             state;
    logic [ADDR_W-1:0] clrPtr;
    logic [ADDR_W-1:0] fifoAddr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifoData [FIFO_DEPTH];
    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic              rdFromRam;
    logic              fifoEmpty;
    logic              push;
    logic              pop;

    assign fifoEmpty = (fifoCount == '0);
    assign clearing  = (state == CLEAR);
    assign wrReady   = (state == RUN) && (fifoCount < DEPTH_C);
    assign push      = wrReq && wrReady;
    // The buffer only drains in RUN cycles the display port leaves free.
    assign pop       = (state == RUN) && !rdReq && !fifoEmpty;

    // Clear sequencer: sweep every address once, then hand over to arbitration.
    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            state  <= CLEAR;
            clrPtr <= '0;
        end else if (state == CLEAR) begin
            if (clrPtr == CLR_LAST) begin
                state <= RUN;
            end else begin
                clrPtr <= clrPtr + ADDR_W'(1);
            end
        end
    end

    // RAM command: clear write, else display read, else buffered write, else idle.
    always_comb begin
        ramEn     = 1'b0;
        ramWe     = 1'b0;
        ramAddr   = '0;
        ramWrData = '0;
        if (!nreset) begin
            ramEn = 1'b0;
        end else if (state == CLEAR) begin
            ramEn   = 1'b1;
            ramWe   = 1'b1;
            ramAddr = clrPtr;
        end else if (rdReq) begin
            ramEn   = 1'b1;
            ramAddr = rdAddr;
        end else if (!fifoEmpty) begin
            ramEn     = 1'b1;
            ramWe     = 1'b1;
            ramAddr   = fifoAddr[headPtr];
            ramWrData = fifoData[headPtr];
        end
    end

    // Read response tracking: reads during the clear return zero without touching RAM.
    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            rdValid   <= 1'b0;
            rdFromRam <= 1'b0;
        end else begin
            rdValid   <= rdReq;
            rdFromRam <= rdReq && (state == RUN);
        end
    end

    assign rdData = (rdValid && rdFromRam) ? ramRdData : '0;

    // Write buffer bookkeeping and sticky drop flag.
    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            fifoCount <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                tailPtr <= tailPtr + PTR_W'(1);
            end
            if (pop) begin
                headPtr <= headPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + CNT_W'(1);
                2'b01:   fifoCount <= fifoCount - CNT_W'(1);
                default: fifoCount <= fifoCount;
            endcase
            if (wrReq && !wrReady) begin
                overflow <= 1'b1;
            end
        end
    end

    // Write buffer storage; contents are meaningless while the count is zero.
    always_ff @(posedge mainClk) begin
        if (push) begin
            fifoAddr[tailPtr] <= wrAddr;
            fifoData[tailPtr] <= wrData;
        end
    end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a small behavioural RAM,
// a RAM-write queue and a read-data queue.
`timescale 1ns/1ps
module tb_frame_buffer_arbiter;

    localparam int AW = 4;
    localparam int DW = 2;
    localparam int FD = 4;

    logic          mainClk;
    logic          nreset;
    logic          rdReq;
    logic [AW-1:0] rdAddr;
    logic [DW-1:0] rdData;
    logic          rdValid;
    logic          wrReq;
    logic [AW-1:0] wrAddr;
    logic [DW-1:0] wrData;
    logic          wrReady;
    logic          ramEn;
    logic          ramWe;
    logic [AW-1:0] ramAddr;
    logic [DW-1:0] ramWrData;
    logic [DW-1:0] ramRdData;
    logic          clearing;
    logic          overflow;
    logic [$clog2(FD):0] fifoCount;

    int total = 0;
    int bad   = 0;

    logic [AW+DW-1:0] exp_q [$];
    logic [DW-1:0]    rd_q [$];
    logic [DW-1:0]    mem [1<<AW];
    logic             rdExpect;
    logic [DW-1:0]    rdExp;
    logic [AW+DW-1:0] wrExp;

    logic [DW-1:0] d40 [5];
    logic [AW-1:0] a41 [5];
    logic [DW-1:0] d41 [5];
    logic [DW-1:0] d44 [4];

    frame_buffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
        .mainClk(mainClk), .nreset(nreset),
        .rdReq(rdReq), .rdAddr(rdAddr), .rdData(rdData), .rdValid(rdValid),
        .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrReady(wrReady),
        .ramEn(ramEn), .ramWe(ramWe), .ramAddr(ramAddr), .ramWrData(ramWrData),
        .ramRdData(ramRdData), .clearing(clearing), .overflow(overflow),
        .fifoCount(fifoCount)
    );

    // clock
    initial mainClk = 1'b0;
    always #5 mainClk = ~mainClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mainClk);
        #1;
    endtask

    // behavioural single-port RAM, read data one cycle after the command
    always @(posedge mainClk) begin
        if (ramEn) begin
            if (ramWe) mem[ramAddr] <= ramWrData;
            else       ramRdData <= mem[ramAddr];
        end
    end

    // every rdReq must be answered in the following cycle
    always @(posedge mainClk or negedge nreset) begin
        if (!nreset) rdExpect <= 1'b0;
        else         rdExpect <= rdReq;
    end

    // scoreboard: read responses and run-time RAM writes
    always @(negedge mainClk) begin
        check("rd_valid", 32'(rdValid), 32'(rdExpect));
        if (rdValid) begin
            if (rd_q.size() == 0) begin
                check("rd_extra", 32'd1, 32'd0);
            end else begin
                rdExp = rd_q.pop_front();
                check("rd_data", 32'(rdData), 32'(rdExp));
            end
        end else begin
            check("rd_idle_zero", 32'(rdData), 32'd0);
        end
        if (nreset && ramEn && ramWe && !clearing) begin
            if (exp_q.size() == 0) begin
                check("wr_extra", 32'd1, 32'd0);
            end else begin
                wrExp = exp_q.pop_front();
                check("ram_write", 32'({ramAddr, ramWrData}), 32'(wrExp));
            end
        end
    end

    initial begin
        d40 = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
        a41 = '{4'd1, 4'd9, 4'd10, 4'd11, 4'd12};
        d41 = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
        d44 = '{2'd1, 2'd2, 2'd3, 2'd1};
        ramRdData = '0;
        nreset = 1'b0;
        rdReq = 1'b0; rdAddr = '0;
        wrReq = 1'b0; wrAddr = '0; wrData = '0;
        repeat (2) @(posedge mainClk);
        #1;

        // reset state
        check("rst_outs", 32'({clearing, ramEn, ramWe, rdValid, rdData, overflow, wrReady}), 32'b1000_0000);
        check("rst_count", 32'(fifoCount), 32'd0);

        // clear sweep with one read in the middle
        nreset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                rdReq = 1'b1; rdAddr = 4'd7; rd_q.push_back(2'd0);
            end else begin
                rdReq = 1'b0;
            end
            #1;
            check("clr_cmd", 32'({ramEn, ramWe, ramAddr, ramWrData, clearing, wrReady}),
                  32'({1'b1, 1'b1, 4'(i), 2'b00, 1'b1, 1'b0}));
            tick();
        end
        rdReq = 1'b0;
        #1;
        check("run_idle", 32'({clearing, wrReady, ramEn, overflow}), 32'b0100);

        // writes with no reads pass straight through
        for (int k = 0; k < 5; k++) begin
            tick();
            wrReq = 1'b1; wrAddr = 4'(k); wrData = d40[k];
            exp_q.push_back({4'(k), d40[k]});
            #1;
            check("w40_ready", 32'(wrReady), 32'd1);
            check("w40_cnt_le1", 32'(fifoCount <= 1), 32'd1);
        end
        tick();
        wrReq = 1'b0;
        repeat (3) tick();
        check("w40_drained", 32'(fifoCount), 32'd0);

        // continuous reads starve writes; fifth write is dropped; no forwarding
        rdReq = 1'b1; rdAddr = 4'd1;
        for (int k = 0; k < 5; k++) begin
            wrReq = 1'b1; wrAddr = a41[k]; wrData = d41[k];
            rd_q.push_back(2'd2);
            if (k < 4) exp_q.push_back({a41[k], d41[k]});
            #1;
            check("w41_cnt", 32'(fifoCount), 32'(k));
            check("w41_ready", 32'(wrReady), 32'(k < 4));
            tick();
        end
        wrReq = 1'b0;
        rd_q.push_back(2'd2);
        #1;
        check("w41_overflow", 32'(overflow), 32'd1);
        check("w41_full", 32'({fifoCount, wrReady, ramWe}), 32'({3'd4, 1'b0, 1'b0}));
        tick();
        rdReq = 1'b0;
        repeat (5) tick();
        check("w41_drained", 32'(fifoCount), 32'd0);
        rdReq = 1'b1; rdAddr = 4'd1; rd_q.push_back(2'd3);
        tick();
        rdReq = 1'b0;
        repeat (2) tick();

        // full buffer: pop without push, space returns next cycle
        rdReq = 1'b1; rdAddr = 4'd0;
        for (int k = 0; k < 4; k++) begin
            wrReq = 1'b1; wrAddr = 4'(12 + k); wrData = 2'd3;
            exp_q.push_back({4'(12 + k), 2'd3});
            rd_q.push_back(2'd1);
            #1;
            check("w43_ready", 32'(wrReady), 32'd1);
            tick();
        end
        rdReq = 1'b0; wrReq = 1'b1; wrAddr = 4'd2; wrData = 2'd1;
        #1;
        check("w43_blocked", 32'({fifoCount, wrReady, ramEn, ramWe}), 32'({3'd4, 1'b0, 1'b1, 1'b1}));
        tick();
        wrReq = 1'b0;
        #1;
        check("w43_space", 32'({fifoCount, wrReady}), 32'({3'd3, 1'b1}));
        repeat (4) tick();
        check("w43_drained", 32'(fifoCount), 32'd0);

        // written pixel reads back after drain
        wrReq = 1'b1; wrAddr = 4'd3; wrData = 2'd2;
        exp_q.push_back({4'd3, 2'd2});
        tick();
        wrReq = 1'b0;
        repeat (2) tick();
        rdReq = 1'b1; rdAddr = 4'd3; rd_q.push_back(2'd2);
        #1;
        check("rd42_cmd", 32'({ramEn, ramWe, ramAddr}), 32'({1'b1, 1'b0, 4'd3}));
        tick();
        rdReq = 1'b0;
        repeat (2) tick();

        // reset mid-drain discards the buffer and restarts the clear
        rdReq = 1'b1; rdAddr = 4'd3;
        for (int k = 0; k < 4; k++) begin
            wrReq = 1'b1; wrAddr = 4'(4 + k); wrData = d44[k];
            exp_q.push_back({4'(4 + k), d44[k]});
            rd_q.push_back(2'd2);
            tick();
        end
        rdReq = 1'b0; wrReq = 1'b0;
        tick();
        check("w44_cnt3", 32'(fifoCount), 32'd3);
        nreset = 1'b0;
        #1;
        check("w44_rst_cnt", 32'(fifoCount), 32'd0);
        check("w44_rst_outs", 32'({overflow, clearing, ramEn, ramWe, rdValid, wrReady}), 32'b010000);
        exp_q.delete();
        repeat (2) tick();
        nreset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("w44_reclear", 32'({ramEn, ramWe, ramAddr, clearing}), 32'({1'b1, 1'b1, 4'(i), 1'b1}));
            tick();
        end

        check("wr_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
